// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state/owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRV_I = 1'b0,
    SRV_D = 1'b1
  } srv_e;

  // On a tie, hand the port to whichever side was not served last.
  function automatic srv_e arb_pick_rr(input logic i_req, input logic d_req, input srv_e last_srv);
    if (i_req && d_req) begin
      return (last_srv == SRV_I) ? SRV_D : SRV_I;
    end
    return d_req ? SRV_D : SRV_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_beat_counter.sv
// rtl/mem_port_arbiter_burst_beat_counter.sv - word index within a line burst
// Wraps naturally at LINE_WORDS since the line size is a power of two.
module burst_beat_counter #(
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [$clog2(LINE_WORDS)-1:0] beat,
  output logic                          last
);

  localparam int BEAT_W = $clog2(LINE_WORDS);

  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr) begin
      beat_d = '0;
    end else if (inc) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between ICache refills and DCache refill/writeback
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed D-over-I priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wnext,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W  = $clog2(LINE_WORDS);
  localparam int BYTE_SH = $clog2(DATA_W / 8);

  arb_state_e        state_q, state_d;
  srv_e              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;

  logic [BEAT_W-1:0] beat;
  logic              beat_last;
  logic              gnt_i, gnt_d, gnt;
  logic              burst_end;
  srv_e              win;
  logic [ADDR_W-1:0] beat_off;

  assign gnt_i     = (state_q == ST_GNT_I);
  assign gnt_d     = (state_q == ST_GNT_D);
  assign gnt       = gnt_i | gnt_d;
  assign burst_end = gnt & mem_ack & beat_last;

  // Holding the counter clear in IDLE guarantees every burst starts at beat 0.
  burst_beat_counter #(
    .LINE_WORDS(LINE_WORDS)
  ) u_beat (
    .clk (CPU_CLK),
    .rst (CPU_RST),
    .clr (state_q == ST_IDLE),
    .inc (gnt & mem_ack),
    .beat(beat),
    .last(beat_last)
  );

`ifdef ARB_ROUND_ROBIN_EN
  srv_e last_srv_q, last_srv_d;

  always_comb begin
    last_srv_d = last_srv_q;
    if (burst_end) begin
      last_srv_d = owner_q;
    end
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      last_srv_q <= SRV_I;
    end else begin
      last_srv_q <= last_srv_d;
    end
  end

  assign win = arb_pick_rr(i_req, d_req, last_srv_q);
`else
  assign win = d_req ? SRV_D : SRV_I;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    we_d    = we_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          owner_d = win;
          if (win == SRV_D) begin
            state_d = ST_GNT_D;
            base_d  = d_addr;
            we_d    = d_we;
          end else begin
            state_d = ST_GNT_I;
            base_d  = i_addr;
            we_d    = 1'b0;
          end
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (burst_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q <= ST_IDLE;
      owner_q <= SRV_I;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      we_q    <= we_d;
    end
  end

  assign beat_off  = ADDR_W'(beat) << BYTE_SH;

  assign mem_req   = gnt;
  assign mem_we    = gnt_d & we_q;
  assign mem_addr  = base_q + beat_off;
  assign mem_wdata = d_wdata;

  // Read data is forwarded combinationally so the cache sees the word in the ack cycle.
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign i_rvalid  = gnt_i & mem_ack;
  assign d_rvalid  = gnt_d & mem_ack & ~we_q;
  assign d_wnext   = gnt_d & mem_ack & we_q;

  assign i_done    = (state_q == ST_DONE) & (owner_q == SRV_I);
  assign d_done    = (state_q == ST_DONE) & (owner_q == SRV_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.LINE_WORDS(8), .ADDR_W(32), .DATA_W(32)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial forever #5 CPU_CLK = ~CPU_CLK;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        is_d;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    cyc          = 0;
  int    ack_gap      = 1;
  int    ack_cnt      = 0;
  bit    spurious     = 1'b0;

  always @(posedge CPU_CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic push_burst(input logic [31:0] base, input logic we, input logic is_d,
                            input logic [31:0] wd0);
    beat_t e;
    for (int k = 0; k < 8; k++) begin
      e.addr = base + 32'(k * 4);
      e.we   = we;
      e.is_d = is_d;
      e.data = we ? wd0 + 32'(k) : mem_word(e.addr);
      exp_q.push_back(e);
    end
  endtask

  // Memory model and writeback requester: ack pattern follows ack_gap, data advances on d_wnext.
  initial begin : responder
    logic wn;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CPU_CLK);
      wn = d_wnext;
      @(posedge CPU_CLK);
      #1;
      if (wn) d_wdata = d_wdata + 32'd1;
      if (mem_req) begin
        ack_cnt++;
        mem_ack = ((ack_cnt % ack_gap) == 0);
      end else begin
        ack_cnt = 0;
        mem_ack = spurious;
      end
      mem_rdata = mem_word(mem_addr);
    end
  end

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge CPU_CLK);
      if (mem_req && mem_ack && !CPU_RST) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: beat at addr=%h, required no beat", mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr) begin
            tests_failed++;
            $display("FAIL sb_addr: got %h required %h", mem_addr, e.addr);
          end
          tests_run++;
          if (mem_we !== e.we) begin
            tests_failed++;
            $display("FAIL sb_we: got %b required %b", mem_we, e.we);
          end
          tests_run++;
          if (e.we) begin
            if ({d_wnext, mem_wdata} !== {1'b1, e.data}) begin
              tests_failed++;
              $display("FAIL sb_wdata: got wnext=%b data=%h required 1 %h", d_wnext, mem_wdata, e.data);
            end
          end else if (e.is_d) begin
            if ({d_rvalid, i_rvalid, d_rdata} !== {2'b10, e.data}) begin
              tests_failed++;
              $display("FAIL sb_d_read: got dv=%b iv=%b data=%h required 1 0 %h", d_rvalid, i_rvalid, d_rdata, e.data);
            end
          end else begin
            if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, e.data}) begin
              tests_failed++;
              $display("FAIL sb_i_read: got iv=%b dv=%b data=%h required 1 0 %h", i_rvalid, d_rvalid, i_rdata, e.data);
            end
          end
        end
      end
    end
  end

  task automatic wait_done(output int first_req, output int last_ack, output int done_cyc,
                           output int beats, output bit is_d, output bit timeout);
    first_req = -1; last_ack = -1; done_cyc = -1; beats = 0; is_d = 1'b0; timeout = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge CPU_CLK);
      if (mem_req && first_req < 0) first_req = cyc;
      if (mem_req && mem_ack) begin
        last_ack = cyc;
        beats++;
      end
      if (i_done || d_done) begin
        done_cyc = cyc;
        is_d     = d_done;
        timeout  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    CPU_RST = 1'b1;
    repeat (3) @(negedge CPU_CLK);
    tests_run++;
    if ({mem_req, i_done, d_done, i_rvalid, d_rvalid, d_wnext} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 000000",
               {mem_req, i_done, d_done, i_rvalid, d_rvalid, d_wnext});
    end
    CPU_RST = 1'b0;
    repeat (2) @(negedge CPU_CLK);
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: mem_req got %b required 0", mem_req);
    end
  endtask

  task automatic test_i_refill();
    int fr, la, dc, nb, rc;
    bit isd, to;
    ack_gap = 2;
    push_burst(32'h100, 1'b0, 1'b0, 32'h0);
    i_addr = 32'h100;
    i_req  = 1'b1;
    rc     = cyc;
    wait_done(fr, la, dc, nb, isd, to);
    i_req = 1'b0;
    tests_run++;
    if (to || isd !== 1'b0) begin
      tests_failed++;
      $display("FAIL i_refill_done: timeout=%b is_d=%b required 0 0", to, isd);
    end
    tests_run++;
    if (fr !== rc + 1) begin
      tests_failed++;
      $display("FAIL i_refill_latency: mem_req cycle %0d required %0d", fr, rc + 1);
    end
    tests_run++;
    if (nb !== 8) begin
      tests_failed++;
      $display("FAIL i_refill_beats: got %0d required 8", nb);
    end
    tests_run++;
    if (dc !== la + 1) begin
      tests_failed++;
      $display("FAIL i_refill_done_timing: done cycle %0d required %0d", dc, la + 1);
    end
    @(negedge CPU_CLK);
    tests_run++;
    if ({i_done, mem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL i_refill_pulse: got done=%b req=%b required 0 0", i_done, mem_req);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL i_refill_drain: %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int fr, la, dc, nb, rc, d_dc;
    bit isd, to;
    ack_gap = 1;
    push_burst(32'h300, 1'b0, 1'b1, 32'h0);
    push_burst(32'h180, 1'b0, 1'b0, 32'h0);
    d_addr = 32'h300; d_we = 1'b0; i_addr = 32'h180;
    d_req  = 1'b1;    i_req = 1'b1;
    rc     = cyc;
    wait_done(fr, la, dc, nb, isd, to);
    d_req = 1'b0;
    d_dc  = dc;
    tests_run++;
    if (to || isd !== 1'b1 || fr !== rc + 1 || nb !== 8) begin
      tests_failed++;
      $display("FAIL b2b_first: timeout=%b is_d=%b start=%0d beats=%0d required 0 1 %0d 8",
               to, isd, fr, nb, rc + 1);
    end
    wait_done(fr, la, dc, nb, isd, to);
    i_req = 1'b0;
    tests_run++;
    if (to || isd !== 1'b0 || nb !== 8) begin
      tests_failed++;
      $display("FAIL b2b_second: timeout=%b is_d=%b beats=%0d required 0 0 8", to, isd, nb);
    end
    tests_run++;
    if (fr !== d_dc + 2) begin
      tests_failed++;
      $display("FAIL b2b_idle_gap: I grant cycle %0d required %0d", fr, d_dc + 2);
    end
    @(negedge CPU_CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_drain: %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_d_writeback();
    int fr, la, dc, nb;
    bit isd, to;
    ack_gap = 1;
    d_wdata = 32'hC0DE_0000;
    push_burst(32'h200, 1'b1, 1'b1, 32'hC0DE_0000);
    d_addr = 32'h200; d_we = 1'b1; d_req = 1'b1;
    wait_done(fr, la, dc, nb, isd, to);
    d_req = 1'b0;
    tests_run++;
    if (to || isd !== 1'b1 || nb !== 8) begin
      tests_failed++;
      $display("FAIL wb_done: timeout=%b is_d=%b beats=%0d required 0 1 8", to, isd, nb);
    end
    tests_run++;
    if (d_wdata !== 32'hC0DE_0008) begin
      tests_failed++;
      $display("FAIL wb_wnext_count: wdata %h required c0de0008", d_wdata);
    end
    @(negedge CPU_CLK);
    d_we = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wb_drain: %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_arbitration_order();
    int fr, la, dc, nb;
    bit isd, to;
    bit order[3];
`ifdef ARB_ROUND_ROBIN_EN
    order = '{1'b1, 1'b0, 1'b1};
`else
    order = '{1'b1, 1'b1, 1'b1};
`endif
    CPU_RST = 1'b1;
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    ack_gap = 1;
    for (int b = 0; b < 3; b++) begin
      if (order[b]) push_burst(32'h400, 1'b0, 1'b1, 32'h0);
      else          push_burst(32'h500, 1'b0, 1'b0, 32'h0);
    end
    d_addr = 32'h400; d_we = 1'b0; i_addr = 32'h500;
    d_req  = 1'b1;    i_req = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_done(fr, la, dc, nb, isd, to);
      tests_run++;
      if (to || isd !== order[b]) begin
        tests_failed++;
        $display("FAIL arb_order_%0d: timeout=%b owner_is_d=%b required 0 %b", b, to, isd, order[b]);
      end
    end
    d_req = 1'b0;
    i_req = 1'b0;
    @(negedge CPU_CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL arb_drain: %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_burst();
    int fr, la, dc, nb, acks;
    bit isd, to, seen;
    ack_gap = 1;
    push_burst(32'h600, 1'b0, 1'b1, 32'h0);
    d_addr = 32'h600; d_we = 1'b0; d_req = 1'b1;
    acks = 0;
    for (int n = 0; n < 50 && acks < 3; n++) begin
      @(negedge CPU_CLK);
      if (mem_req && mem_ack) acks++;
    end
    tests_run++;
    if (acks != 3) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: acks %0d required 3", acks);
    end
    @(posedge CPU_CLK);
    #2;
    CPU_RST = 1'b1;
    d_req   = 1'b0;
    #1;
    tests_run++;
    if ({mem_req, d_rvalid, d_done, i_done, d_wnext} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %b required 00000", {mem_req, d_rvalid, d_done, i_done, d_wnext});
    end
    exp_q.delete();
    repeat (2) @(negedge CPU_CLK);
    CPU_RST = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge CPU_CLK);
      if (mem_req || i_done || d_done) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: activity seen=%b required 0", seen);
    end
    push_burst(32'h100, 1'b0, 1'b0, 32'h0);
    i_addr = 32'h100; i_req = 1'b1;
    wait_done(fr, la, dc, nb, isd, to);
    i_req = 1'b0;
    tests_run++;
    if (to || isd !== 1'b0 || nb !== 8) begin
      tests_failed++;
      $display("FAIL rst_mid_after: timeout=%b is_d=%b beats=%0d required 0 0 8", to, isd, nb);
    end
    @(negedge CPU_CLK);
  endtask

  task automatic test_spurious_and_wrap();
    int fr, la, dc, nb, rc;
    bit isd, to, seen;
    spurious = 1'b1;
    seen     = 1'b0;
    repeat (4) begin
      @(negedge CPU_CLK);
      if (mem_req || i_rvalid || d_rvalid || d_wnext || i_done || d_done) seen = 1'b1;
    end
    spurious = 1'b0;
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_ack: activity seen=%b required 0", seen);
    end
    @(negedge CPU_CLK);
    ack_gap = 1;
    push_burst(32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0);
    i_addr = 32'hFFFF_FFF0; i_req = 1'b1;
    rc     = cyc;
    wait_done(fr, la, dc, nb, isd, to);
    i_req = 1'b0;
    tests_run++;
    if (to || isd !== 1'b0 || nb !== 8 || fr !== rc + 1) begin
      tests_failed++;
      $display("FAIL wrap_burst: timeout=%b is_d=%b beats=%0d start=%0d required 0 0 8 %0d",
               to, isd, nb, fr, rc + 1);
    end
    @(negedge CPU_CLK);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wrap_drain: %0d beats left required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    CPU_RST = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0;  d_addr = '0;  d_wdata = '0;
    test_reset();
    test_i_refill();
    test_back_to_back();
    test_d_writeback();
    test_arbitration_order();
    test_reset_mid_burst();
    test_spurious_and_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
